// File: rtl/tt_lut_seq.sv
// Programmable registered truth table: NUM_IN-input x NUM_OUT-output LUT, runtime-loadable, with full-table sweep.
// Latency: one cycle from an accepted in_vec (or sweep step) to out_valid/out_vec/out_idx.
// Backpressure: the single output register holds while out_valid && !out_ready; in_ready and sweep stepping stall.
// Ports: cfg_valid/cfg_ready/cfg_addr/cfg_data load entries (IDLE only); in_valid/in_ready/in_vec request evaluation;
//        sweep_start starts a full-table sweep, busy marks SWEEP; out_valid/out_ready/out_vec/out_idx/out_last carry results.
module tt_lut_seq #(
   parameter int                 NUM_IN    = 3,
   parameter int                 NUM_OUT   = 2,
   parameter logic [NUM_OUT-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [NUM_IN-1:0]  cfg_addr,
   input  logic [NUM_OUT-1:0] cfg_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUM_IN-1:0]  in_vec,
   input  logic               sweep_start,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_vec,
   output logic [NUM_IN-1:0]  out_idx,
   output logic               out_last
);

   localparam int DEPTH = 1 << NUM_IN;
   // One spare bit so the counter cannot wrap before the last beat is seen.
   localparam int CNT_W = NUM_IN + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [NUM_OUT-1:0] tbl_q [DEPTH];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [NUM_OUT-1:0] out_vec_q, out_vec_d;
   logic [NUM_IN-1:0]  out_idx_q, out_idx_d;
   logic               out_last_q, out_last_d;

   logic adv;
   logic cnt_last;
   logic sweep_ld;
   logic eval_fire;
   logic cfg_fire;

   // Output register may take a new value when empty or being drained.
   assign adv      = !out_valid_q || out_ready;
   assign cnt_last = (cnt_q == LAST_CNT);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (sweep_start) state_d = ST_SWEEP;
         // Leave only once the final beat has actually been loaded.
         ST_SWEEP: if (adv && cnt_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = 1'b0;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      sweep_ld  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready  = adv;
            cfg_ready = 1'b1;
         end
         ST_SWEEP: begin
            busy     = 1'b1;
            sweep_ld = adv;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign eval_fire = in_valid && in_ready;
   assign cfg_fire  = cfg_valid && cfg_ready;

   // ---------------- datapath next state ----------------
   always_comb begin
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_vec_d   = out_vec_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      if (state_q == ST_IDLE && sweep_start) begin
         cnt_d = '0;
      end else if (sweep_ld) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Table is read before any same-cycle config write lands (read-before-write).
      if (eval_fire) begin
         out_valid_d = 1'b1;
         out_vec_d   = tbl_q[in_vec];
         out_idx_d   = in_vec;
         out_last_d  = 1'b0;
      end else if (sweep_ld) begin
         out_valid_d = 1'b1;
         out_vec_d   = tbl_q[cnt_q[NUM_IN-1:0]];
         out_idx_d   = cnt_q[NUM_IN-1:0];
         out_last_d  = cnt_last;
      end else if (adv) begin
         out_valid_d = 1'b0;
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_vec_q   <= out_vec_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= RESET_VAL;
         end
      end else if (cfg_fire) begin
         tbl_q[cfg_addr] <= cfg_data;
      end
   end

   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: doc/tt_lut_seq.md
Name: tt_lut_seq

Overview:
Programmable, registered truth-table evaluator. It is the parametrised successor of the fixed 3-input, 2-output case-statement gates used as synthesis inputs. The table is NUM_IN inputs by NUM_OUT outputs and is loaded at runtime through a config port. Evaluation runs through a valid/ready stream. A built-in sweep mode enumerates every input combination and emits the full truth table, so downstream netlist checkers can compare against synthesised circuits.

Parameters:
NUM_IN, 3, number of input bits; legal range 1..6; table depth DEPTH = 2^NUM_IN.
NUM_OUT, 2, number of output bits per table entry; legal range 1..16.
RESET_VAL, 0 (NUM_OUT bits), value loaded into every table entry at reset.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
cfg_valid  in  1  table write request.
cfg_ready  out  1  table write accepted when high together with cfg_valid.
cfg_addr  in  NUM_IN  table entry index; bit 0 = in1 ordering, i.e. {inN..in1}.
cfg_data  in  NUM_OUT  entry value; MSB = out1.
in_valid  in  1  evaluation request.
in_ready  out  1  evaluation accepted when high together with in_valid.
in_vec  in  NUM_IN  input combination to evaluate.
sweep_start  in  1  single-cycle pulse that starts a full-table sweep.
busy  out  1  high while the FSM is in SWEEP.
out_valid  out  1  result held valid.
out_ready  in  1  downstream accepts the result.
out_vec  out  NUM_OUT  table value for the evaluated or swept index.
out_idx  out  NUM_IN  index that produced out_vec.
out_last  out  1  high on the final sweep beat (index DEPTH-1); 0 for EVAL results.

Behaviour:
- Reset (asynchronous assert; deassert synchronised by the integration):
  - all table entries = RESET_VAL; FSM = IDLE;
  - out_valid, out_vec, out_idx, out_last, busy = 0; sweep counter = 0.
- Storage: DEPTH x NUM_OUT flop array; no RAM macro.
- Output register: single entry. It loads when out_valid == 0 or out_ready == 1 (the "adv" condition). It holds stable while out_valid && !out_ready.
- FSM states:
  - IDLE: in_ready = adv. cfg_ready = 1. Accepted input produces out_vec = table[in_vec], out_idx = in_vec, out_last = 0, out_valid = 1 on the next edge (latency 1).
  - IDLE -> SWEEP: on sweep_start. Counter = 0. cfg_ready = 0 and in_ready = 0 from the next cycle. If an eval is accepted in the same cycle as sweep_start, the eval result is emitted first and the sweep begins behind it.
  - SWEEP: when adv holds, register table[cnt] with out_idx = cnt and out_last = (cnt == DEPTH-1), then cnt++. busy = 1.
  - SWEEP -> IDLE: after the beat with out_last = 1 is loaded. Emits exactly DEPTH beats, indices ascending with no gaps, under arbitrary back-pressure.
  - sweep_start while in SWEEP: ignored.
- Config writes are accepted in IDLE only and take effect on the next edge.
- Simultaneous cfg write and eval to the same address in one cycle: eval returns the OLD value (read-before-write).
- Back-to-back evals with out_ready held at 1 give one result per cycle.
- in_valid during SWEEP: not accepted (in_ready = 0), so no loss.
- Reset mid-sweep: sweep aborts immediately, the table reverts to RESET_VAL, and no further beats are emitted.
- Widths: cnt is NUM_IN+1 bits internally so it cannot wrap before the last beat is detected. No arithmetic is performed on table data.

Test Plan:
1. Reset, then evaluate in_vec 0..7 (defaults) -> out_vec = 2'b00 for all, latency 1 cycle, out_last = 0.
2. Write table {0:01, 1:10, 2:11, 3:01, 4:01, 5:10, 6:11, 7:00}, evaluate in_vec 6 -> out_vec = 2'b11, out_idx = 6.
3. Write addr 5 = 2'b01 and evaluate in_vec 5 in the same cycle -> result 2'b10 (old value); re-evaluate -> 2'b01.
4. sweep_start with out_ready toggling randomly -> exactly 8 beats, out_idx 0..7 in order, out_vec matches the table, out_last only on idx 7, busy falls after the final beat, cfg_ready/in_ready = 0 throughout.
5. Hold out_ready = 0 for 5 cycles mid-eval -> out_vec/out_idx stable, in_ready = 0; release -> next input accepted the same cycle.
6. Assert rst_n = 0 at sweep beat 3 -> outputs = 0 asynchronously, busy = 0; after release, evaluate in_vec 2 -> 2'b00 (RESET_VAL).
